dec_scan_ctrl: RTL and testbench
================================

# dec_scan_ctrl

Scan controller that sits directly upstream of the 3-to-8 decoders (`dec3to8_shift` / `dec3to8_case`) and drives their `in` and `en` inputs. It steps a 3-bit index through 0..7 (or 7..0). Each index is held for a programmable dwell time. Two modes are supported: continuous scanning, and a single sweep that ends with a done pulse. All outputs are registered, so the downstream decoder sees glitch-free `in`/`en`.

## Interface
- `DWELL_W`, default 8 — width of dwell-time input and internal dwell counter
- `clk`  in  1  — single clock; all state changes on rising edge
- `rst`  in  1  — reset, synchronous, active-high
- `start`  in  1  — begin scan; honoured only in IDLE
- `stop`  in  1  — abort scan; return to IDLE
- `pause`  in  1  — level; freezes scan while high
- `dir`  in  1  — 0 = up (0→7), 1 = down (7→0); sampled at accepted start
- `mode`  in  1  — 0 = continuous, 1 = single sweep; sampled at accepted start
- `dwell`  in  DWELL_W  — cycles per index; 0 treated as 1; sampled at accepted start
- `sel`  out  3  — index to decoder `in`
- `en`  out  1  — decoder enable; high in RUN and HOLD
- `busy`  out  1  — high in RUN and HOLD
- `wrap`  out  1  — one-cycle pulse when index wraps in continuous mode
- `done`  out  1  — one-cycle pulse at normal end of single sweep

## Operation
- States: IDLE, RUN, HOLD.
- Priority each cycle: rst > stop > pause > start.
- Reset values: state=IDLE, sel=0, en=0, busy=0, wrap=0, done=0, dwell counter=0, latched dir/mode/dwell=0.
- IDLE:
  - start=1 and stop=0 → RUN.
  - sel ← (dir ? 7 : 0); latch dir, mode, max(dwell,1); dwell counter ← 0.
  - sel otherwise holds its last value; en=0.
- RUN:
  - pause=1 → HOLD.
  - Otherwise the dwell counter increments. When counter == D−1 (D = latched dwell), counter ← 0 and sel steps ±1 mod 8.
  - Terminal step (up: 7→0; down: 0→7):
    - continuous: wrap step taken; wrap=1 for that cycle.
    - single sweep: no step. State → IDLE, en ← 0, busy ← 0, done ← 1 for one cycle. sel holds the final index (7 up, 0 down).
- HOLD:
  - Counter and sel frozen; en stays 1.
  - pause=0 → RUN, resuming the count where it stopped.
- stop=1 in RUN or HOLD → IDLE next edge. en=0, no done, no wrap; sel holds.
- start while in RUN or HOLD is ignored.
- start with stop in the same cycle in IDLE → remain IDLE.
- Changing dir/mode/dwell mid-scan has no effect until the next accepted start.

## Timing
- start sampled at edge k → sel = initial index and en=1 visible after edge k.
- Each index is presented for exactly D cycles when pause is not asserted.
- Single sweep, no pause: en high for exactly 8·D cycles. done asserts in the first cycle en is low.
- Continuous: wrap asserts in the same cycle sel shows the wrapped value (0 up, 7 down).
- Pause adds exactly N cycles per N cycles held high in RUN/HOLD.
- rst mid-scan → all outputs at reset values after the next edge, regardless of other inputs.
- done and wrap are never high in the same cycle. Neither is ever high for more than one cycle.

## Structure
- Shared package `dec_scan_pkg`:
  - state enum {IDLE, RUN, HOLD}
  - `SEL_W`=3, `NUM_IDX`=8
- Natural sub-module: `dwell_timer`. It holds a DWELL_W-bit counter with load/clear/enable inputs and a terminal-count output; the top FSM instantiates it once.
- The decoder is not instantiated inside; integration pairs `sel`/`en` with `dec3to8_case` in a wrapper bench.

## Test plan
- Reset, then dwell=2, dir=0, mode=1, start pulse:
  - sel goes 0,0,1,1,…,7,7 over 16 cycles.
  - en high for 16 cycles, then done=1 for one cycle with sel=7.
  - Decoder output walks 00000001→10000000.
- dwell=0, dir=1, mode=0, start: sel steps every cycle 7,6,…,0,7; wrap=1 exactly when sel returns to 7; no done.
- dwell=3, pause high for 5 cycles during index 4: index 4 visible for 8 cycles total; en stays 1; sweep length 29 cycles.
- stop asserted while sel=5: next cycle en=0, busy=0, sel=5, no done; a later start restarts from 0.
- start and stop together in IDLE → no change. start asserted during RUN → sequence unaffected.
- rst asserted mid-RUN with pause=1: after the edge sel=0, en=0, state IDLE; the first start afterwards behaves as from power-up.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// ============================================================================
// dec_scan_pkg : shared types and constants for the decoder scan controller
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_scan_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_IDX = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } scan_state_t;

    // Step the index one position; the natural SEL_W-bit overflow gives mod-8.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx,
                                                   input logic            down);
        return down ? (idx - SEL_W'(1)) : (idx + SEL_W'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_scan_ctrl_dwell_timer.sv
// ============================================================================
// dwell_timer : per-index dwell counter with latched limit and terminal count
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               clr_i,
    input  logic               en_i,
    output logic               tc_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] lim_q;

    // A zero dwell is latched as one so every index still lasts a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            lim_q <= (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : (cnt_q + DWELL_W'(1));
        end
    end

    assign tc_o = (cnt_q == (lim_q - DWELL_W'(1)));

endmodule

`default_nettype wire

// File: rtl/dec_scan_ctrl.sv
// ============================================================================
// dec_scan_ctrl : steps a registered 3-bit index/enable for a 3-to-8 decoder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_scan_ctrl
    import dec_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               pause_i,
    input  logic               dir_i,
    input  logic               mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               en_o,
    output logic               busy_o,
    output logic               wrap_o,
    output logic               done_o
);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, busy_q, wrap_q, done_q;
    logic             en_d, busy_d, wrap_d, done_d;
    logic             dir_q, dir_d, mode_q, mode_d;

    logic             active;
    logic             accept;
    logic             tick_en;
    logic             tc;
    logic             last_idx;

    assign active   = (state_q != S_IDLE);
    assign accept   = (state_q == S_IDLE) && start_i && !stop_i;
    assign tick_en  = active && !stop_i && !pause_i;
    assign last_idx = dir_q ? (sel_q == '0) : (sel_q == SEL_W'(NUM_IDX - 1));

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .dwell_i (dwell_i),
        .clr_i   (active && stop_i),
        .en_i    (tick_en),
        .tc_o    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // Leaving HOLD with pause low counts in that same cycle, so a pause
    // of N cycles stretches the scan by exactly N.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (stop_i)                      state_d = S_IDLE;
                else if (pause_i)                state_d = S_HOLD;
                else if (tc && last_idx && mode_q) state_d = S_IDLE;
                else                             state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d  = dir_i ? SEL_W'(NUM_IDX - 1) : '0;
                    dir_d  = dir_i;
                    mode_d = mode_i;
                end
            end
            S_RUN, S_HOLD: begin
                if (tick_en && tc) begin
                    if (last_idx && mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d  = next_idx(sel_q, dir_q);
                        wrap_d = last_idx;
                    end
                end
            end
            default: ;
        endcase
        en_d   = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    assign sel_o  = sel_q;
    assign en_o   = en_q;
    assign busy_o = busy_q;
    assign wrap_o = wrap_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_scan_ctrl.sv
// ============================================================================
// tb_dec_scan_ctrl : scoreboard bench for dec_scan_ctrl against a cycle model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_scan_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0, mode = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [2:0]    sel;
    logic          en, busy, wrap, done;

    dec_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .stop_i  (stop),
        .pause_i (pause),
        .dir_i   (dir),
        .mode_i  (mode),
        .dwell_i (dwell),
        .sel_o   (sel),
        .en_o    (en),
        .busy_o  (busy),
        .wrap_o  (wrap),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       wrap;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;

    // Reference model: "scanning" flag, current index, and cycles spent on it.
    bit m_scan;
    int m_idx, m_spent, m_len;
    bit m_down, m_single;

    function automatic obs_t model_step(input bit r, input bit st, input bit sp,
                                        input bit pa, input bit d, input bit m,
                                        input int dw);
        obs_t o;
        bit   wr = 0, dn = 0;
        if (r) begin
            m_scan = 0; m_idx = 0; m_spent = 0;
        end else if (!m_scan) begin
            if (st && !sp) begin
                m_scan = 1; m_down = d; m_single = m;
                m_len = (dw == 0) ? 1 : dw;
                m_idx = d ? 7 : 0; m_spent = 0;
            end
        end else if (sp) begin
            m_scan = 0;
        end else if (!pa) begin
            m_spent++;
            if (m_spent == m_len) begin
                m_spent = 0;
                if (m_idx == (m_down ? 0 : 7)) begin
                    if (m_single) begin m_scan = 0; dn = 1; end
                    else begin m_idx = m_down ? 7 : 0; wr = 1; end
                end else begin
                    m_idx = m_down ? m_idx - 1 : m_idx + 1;
                end
            end
        end
        o.sel = 3'(m_idx); o.en = m_scan; o.busy = m_scan; o.wrap = wr; o.done = dn;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic cyc(input bit r, input bit st, input bit sp, input bit pa,
                       input bit d, input bit m, input int dw);
        @(negedge clk);
        rst = r; start = st; stop = sp; pause = pa; dir = d; mode = m; dwell = DW'(dw);
        exp_q.push_back(model_step(r, st, sp, pa, d, m, dw));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge the DUT presents a new registered output word.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{sel: sel, en: en, busy: busy, wrap: wrap, done: done};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs @%0t: got sel=%0d en=%b busy=%b wrap=%b done=%b, expected sel=%0d en=%b busy=%b wrap=%b done=%b",
                         $time, a.sel, a.en, a.busy, a.wrap, a.done,
                         e.sel, e.en, e.busy, e.wrap, e.done);
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 1, 5);
        idle(2);

        // single sweep up, dwell 2
        cyc(0, 1, 0, 0, 0, 1, 2);
        idle(20);

        // continuous down, dwell 0 -> 1
        cyc(0, 1, 0, 0, 1, 0, 0);
        idle(18);
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // dwell 3 single up, pause 5 cycles during index 4
        cyc(0, 1, 0, 0, 0, 1, 3);
        idle(13);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        idle(16);

        // stop at index 5, then restart
        cyc(0, 1, 0, 0, 0, 0, 1);
        idle(5);
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 1, 1);
        idle(10);

        // start+stop in idle, start during run
        cyc(0, 1, 1, 0, 1, 0, 1);
        idle(2);
        cyc(0, 1, 0, 0, 0, 1, 2);
        idle(3);
        cyc(0, 1, 0, 0, 1, 0, 7);
        idle(16);

        // reset mid-run with pause high, then fresh start
        cyc(0, 1, 0, 0, 1, 0, 2);
        idle(4);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 1);
        idle(10);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 7) == 0),
                1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)));
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
